// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding / hazard unit.
//   DW_DEF, AW_DEF  : default data and register-address widths
//   FWD_RF          : fwd_sel code meaning "register file value"
//   FWD_STAGE_BASE  : fwd_sel code for stage 0; stage k is FWD_STAGE_BASE + k
//   shadow_entry_t  : one tracked in-flight instruction {v, we, load, dest}
package hazard_pkg;

    localparam int DW_DEF         = 32;
    localparam int AW_DEF         = 5;
    localparam int FWD_RF         = 0;
    localparam int FWD_STAGE_BASE = 1;

    // dest is sized by AW_DEF, so the unit's AW parameter must not exceed it.
    typedef struct packed {
        logic              v;
        logic              we;
        logic              load;
        logic [AW_DEF-1:0] dest;
    } shadow_entry_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port forwarding select.
//   rs          : source register address for this port
//   st_wr_v     : per stage, entry valid and writes a register
//   st_load     : per stage, entry is a load
//   st_dest     : per stage destination, stage k at [k*AW +: AW]
//   stage_data  : per stage result, stage k at [k*DW +: DW]
//   rf_data     : register file value for this port
//   data / sel  : forwarded operand and its source code
//   not_ready   : youngest producer is a load whose data is not yet available
module fwd_port_sel
    import hazard_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 1,
    parameter int SELW     = 2
) (
    input  logic [AW-1:0]       rs,
    input  logic [DEPTH-1:0]    st_wr_v,
    input  logic [DEPTH-1:0]    st_load,
    input  logic [DEPTH*AW-1:0] st_dest,
    input  logic [DEPTH*DW-1:0] stage_data,
    input  logic [DW-1:0]       rf_data,
    output logic [DW-1:0]       data,
    output logic [SELW-1:0]     sel,
    output logic                not_ready
);

    // Walk from oldest to youngest so the youngest hit overrides everything
    // older, including an older ready producer behind a non-ready one.
    always_comb begin
        data      = rf_data;
        sel       = SELW'(FWD_RF);
        not_ready = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (st_wr_v[k] && (st_dest[k*AW +: AW] == rs) && (rs != '0)) begin
                if (st_load[k] && (k < LOAD_RDY)) begin
                    data      = rf_data;
                    sel       = SELW'(FWD_RF);
                    not_ready = 1'b1;
                end else begin
                    data      = stage_data[k*DW +: DW];
                    sel       = SELW'(FWD_STAGE_BASE + k);
                    not_ready = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the in-order pipeline.
//   clk, rst     : clock, asynchronous active-high reset
//   id_*         : instruction in ID (valid, sources, dest, write, load)
//   rf_rdata     : register file read data, port p at [p*DW +: DW]
//   stage_data   : result held in stage k, at [k*DW +: DW]
//   flush        : squash ID and EX
//   fwd_rdata    : forwarded operand per port
//   fwd_sel      : per port, 0 = register file, k+1 = stage k
//   stall        : hold PC/IF/ID, bubble into EX
//   issue        : ID instruction enters EX this cycle
//   stall_cnt    : saturating stall cycle counter
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NRP      = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 1,
    parameter int SELW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [NRP*AW-1:0]   id_rs,
    input  logic                id_we,
    input  logic [AW-1:0]       id_rd,
    input  logic                id_is_load,
    input  logic [NRP*DW-1:0]   rf_rdata,
    input  logic [DEPTH*DW-1:0] stage_data,
    input  logic                flush,
    output logic [NRP*DW-1:0]   fwd_rdata,
    output logic [NRP*SELW-1:0] fwd_sel,
    output logic                stall,
    output logic                issue,
    output logic [31:0]         stall_cnt
);

    shadow_entry_t stage_q [DEPTH];
    shadow_entry_t stage0_d;

    logic [DEPTH-1:0]    st_wr_v;
    logic [DEPTH-1:0]    st_load;
    logic [DEPTH*AW-1:0] st_dest;
    logic [NRP-1:0]      port_not_ready;
    logic                raw_stall;

    always_comb begin
        st_wr_v = '0;
        st_load = '0;
        st_dest = '0;
        for (int k = 0; k < DEPTH; k++) begin
            st_wr_v[k]           = stage_q[k].v & stage_q[k].we;
            st_load[k]           = stage_q[k].load;
            st_dest[k*AW +: AW]  = stage_q[k].dest[AW-1:0];
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_port
        fwd_port_sel #(
            .DW       (DW),
            .AW       (AW),
            .DEPTH    (DEPTH),
            .LOAD_RDY (LOAD_RDY),
            .SELW     (SELW)
        ) u_port_sel (
            .rs         (id_rs[p*AW +: AW]),
            .st_wr_v    (st_wr_v),
            .st_load    (st_load),
            .st_dest    (st_dest),
            .stage_data (stage_data),
            .rf_data    (rf_rdata[p*DW +: DW]),
            .data       (fwd_rdata[p*DW +: DW]),
            .sel        (fwd_sel[p*SELW +: SELW]),
            .not_ready  (port_not_ready[p])
        );
    end

    assign raw_stall = |port_not_ready;
    assign stall     = raw_stall & id_valid & ~flush;
    assign issue     = id_valid & ~stall & ~flush;

    always_comb begin
        stage0_d = '0;
        if (issue) begin
            stage0_d.v    = 1'b1;
            stage0_d.we   = id_we;
            stage0_d.load = id_is_load;
            stage0_d.dest = id_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            stage_q[0] <= stage0_d;
            // A flush also kills the current EX occupant on its way to MEM.
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= (flush && (k == 1)) ? '0 : stage_q[k-1];
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int NRP      = 2;
    localparam int DEPTH    = 3;
    localparam int LOAD_RDY = 1;
    localparam int SELW     = 2;

    logic                clk;
    logic                rst;
    logic                id_valid;
    logic [NRP*AW-1:0]   id_rs;
    logic                id_we;
    logic [AW-1:0]       id_rd;
    logic                id_is_load;
    logic [NRP*DW-1:0]   rf_rdata;
    logic [DEPTH*DW-1:0] stage_data;
    logic                flush;
    logic [NRP*DW-1:0]   fwd_rdata;
    logic [NRP*SELW-1:0] fwd_sel;
    logic                stall;
    logic                issue;
    logic [31:0]         stall_cnt;

    fwd_hazard_unit #(
        .DW(DW), .AW(AW), .NRP(NRP), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SELW(SELW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_we      (id_we),
        .id_rd      (id_rd),
        .id_is_load (id_is_load),
        .rf_rdata   (rf_rdata),
        .stage_data (stage_data),
        .flush      (flush),
        .fwd_rdata  (fwd_rdata),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .issue      (issue),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: in-flight instructions ordered by age, index 0 youngest.
    typedef struct {
        bit v;
        bit we;
        bit ld;
        int dst;
    } rec_t;

    rec_t        pipe[$];
    rec_t        nxt_rec;
    bit          nxt_flush;
    longint      m_cnt;
    bit          nxt_inc;

    task automatic model_reset();
        rec_t b;
        b = '{v: 0, we: 0, ld: 0, dst: 0};
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(b);
        m_cnt = 0;
    endtask

    // Apply inputs, compare every output with the model, remember next state.
    task automatic drive(input bit v, input int rs0, input int rs1, input bit we,
                         input int rd, input bit ld, input bit fl,
                         input logic [31:0] rf0, input logic [31:0] rf1,
                         input logic [31:0] sd0, input logic [31:0] sd1,
                         input logic [31:0] sd2);
        int          rs[NRP];
        logic [31:0] rf[NRP];
        logic [31:0] sd[DEPTH];
        int          e_sel;
        logic [31:0] e_data;
        bit          any_nr;
        bit          e_stall, e_issue;
        rs[0] = rs0; rs[1] = rs1;
        rf[0] = rf0; rf[1] = rf1;
        sd[0] = sd0; sd[1] = sd1; sd[2] = sd2;
        id_valid   = v;
        id_rs      = {AW'(rs1), AW'(rs0)};
        id_we      = we;
        id_rd      = AW'(rd);
        id_is_load = ld;
        flush      = fl;
        rf_rdata   = {rf1, rf0};
        stage_data = {sd2, sd1, sd0};
        #1;
        any_nr = 0;
        for (int p = 0; p < NRP; p++) begin
            e_sel  = 0;
            e_data = rf[p];
            for (int a = 0; a < DEPTH; a++) begin
                if (pipe[a].v && pipe[a].we && pipe[a].dst == rs[p] && rs[p] != 0) begin
                    if (pipe[a].ld && a < LOAD_RDY) any_nr = 1;
                    else begin
                        e_sel  = a + 1;
                        e_data = sd[a];
                    end
                    break;
                end
            end
            check($sformatf("rdata%0d", p), 64'(fwd_rdata[p*DW +: DW]), 64'(e_data));
            check($sformatf("sel%0d", p), 64'(fwd_sel[p*SELW +: SELW]), 64'(e_sel));
        end
        e_stall = any_nr && v && !fl;
        e_issue = v && !e_stall && !fl;
        check("stall", 64'(stall), 64'(e_stall));
        check("issue", 64'(issue), 64'(e_issue));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        nxt_rec   = '{v: e_issue, we: e_issue && we, ld: e_issue && ld, dst: e_issue ? rd : 0};
        nxt_flush = fl;
        nxt_inc   = e_stall;
    endtask

    task automatic tick();
        rec_t b;
        b = '{v: 0, we: 0, ld: 0, dst: 0};
        @(posedge clk);
        pipe.push_front(nxt_rec);
        if (nxt_flush) pipe[1] = b;
        while (pipe.size() > DEPTH) void'(pipe.pop_back());
        if (nxt_inc && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs = '0; id_we = 0; id_rd = '0; id_is_load = 0;
        rf_rdata = '0; stage_data = '0; flush = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state, no in-flight writes
        drive(1, 3, 4, 0, 0, 0, 0, 32'h11, 32'h22, 0, 0, 0);
        check("rst_rdata", 64'(fwd_rdata), {32'h22, 32'h11});
        check("rst_sel", 64'(fwd_sel), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_cnt", 64'(stall_cnt), 64'd0);
        tick();

        // ALU write of $5 forwarded from EX, MEM, WB
        drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 0, 0, 0, 1, 2, 32'hA5A5, 0, 0);
        check("ex_sel", 64'(fwd_sel[SELW-1:0]), 64'd1);
        check("ex_data", 64'(fwd_rdata[DW-1:0]), 64'hA5A5);
        check("ex_stall", 64'(stall), 64'd0);
        tick();
        drive(1, 5, 0, 0, 0, 0, 0, 1, 2, 0, 32'hA5A5, 0);
        check("mem_sel", 64'(fwd_sel[SELW-1:0]), 64'd2);
        tick();
        drive(1, 5, 0, 0, 0, 0, 0, 1, 2, 0, 0, 32'hA5A5);
        check("wb_sel", 64'(fwd_sel[SELW-1:0]), 64'd3);
        tick();

        // Load-use: one stall cycle, then forward from MEM
        drive(1, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu_stall", 64'(stall), 64'd1);
        check("lu_issue", 64'(issue), 64'd0);
        tick();
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD, 0);
        check("lu_cnt", 64'(stall_cnt), 64'd1);
        check("lu_sel", 64'(fwd_sel[SELW-1:0]), 64'd2);
        check("lu_data", 64'(fwd_rdata[DW-1:0]), 64'hDEAD);
        check("lu_issue2", 64'(issue), 64'd1);
        tick();

        // Youngest of two writers wins; $0 never forwards
        drive(1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 9, 9, 0, 0, 0, 0, 0, 0, 32'h2, 32'h1, 0);
        check("yng_rdata", 64'(fwd_rdata), {32'h2, 32'h2});
        tick();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hBAD, 0, 0);
        check("r0_sel", 64'(fwd_sel), 64'd0);
        check("r0_rdata", 64'(fwd_rdata), 64'd0);
        tick();

        // Flush beats load-use and kills the load in EX
        drive(1, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("fl_stall", 64'(stall), 64'd0);
        check("fl_issue", 64'(issue), 64'd0);
        tick();
        drive(1, 7, 7, 0, 0, 0, 0, 32'h77, 32'h77, 32'h1, 32'h2, 32'h3);
        check("fl_cnt", 64'(stall_cnt), 64'd1);
        check("fl_sel", 64'(fwd_sel), 64'd0);
        tick();

        // Asynchronous reset with a load in EX and a dependent in ID
        drive(1, 0, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("ar_pre_stall", 64'(stall), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("ar_stall", 64'(stall), 64'd0);
        check("ar_cnt", 64'(stall_cnt), 64'd0);
        check("ar_sel", 64'(fwd_sel), 64'd0);
        rst = 1'b0;
        model_reset();
        drive(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(3, 0) != 0,
                  int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                  $urandom_range(1, 0) == 1, int'($urandom_range(7, 0)),
                  $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0,
                  $urandom, $urandom, $urandom, $urandom, $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
